// File: rtl/axi_dec_pkg.sv
// axi_dec_pkg: shared FSM states, slave select encoding and AXI response codes for the read decoder.
package axi_dec_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DEF_DATA} state_t;
  typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_S2, SEL_DEF} sel_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi_default_slave.sv
// axi_default_slave: answers unmapped reads with arlen+1 DECERR beats of zero data.
module axi_default_slave
  import axi_dec_pkg::*;
#(
  parameter int DW  = 32,
  parameter int IDW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_en,
  input  logic [3:0]     i_arlen,
  input  logic [IDW-1:0] i_arid,
  input  logic           i_rready,
  output logic           o_arready,
  output logic           o_rvalid,
  output logic [DW-1:0]  o_rdata,
  output logic [IDW-1:0] o_rid,
  output logic [1:0]     o_rresp,
  output logic           o_rlast
);
  logic       r_first;
  logic [3:0] r_cnt;
  // The entry cycle only accepts the address; beats start on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_first <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_first <= i_load;
      r_cnt   <= i_load ? 4'd0 : (o_rvalid && i_rready) ? (o_rlast ? 4'd0 : r_cnt + 4'd1) : r_cnt;
    end
  end
  assign o_arready = i_en & r_first;
  assign o_rvalid  = i_en & ~r_first;
  assign o_rlast   = o_rvalid & (r_cnt == i_arlen);
  assign o_rdata   = '0;
  assign o_rid     = i_arid;
  assign o_rresp   = RESP_DECERR;
endmodule

// File: rtl/axi_rd_decoder_3s.sv
// axi_rd_decoder_3s: routes one arbitrated AR/R transaction to one of three slaves or a DECERR default slave.
// Optional AXI_RD_DECERR_CNT_EN adds a saturating count of default-slave transactions.
module axi_rd_decoder_3s
  import axi_dec_pkg::*;
#(
  parameter int           AW      = 32,
  parameter int           DW      = 32,
  parameter int           IDW     = 8,
  parameter logic [AW-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [AW-1:0] S0_MASK = 32'hFFFF_C000,
  parameter logic [AW-1:0] S1_BASE = 32'h0001_0000,
  parameter logic [AW-1:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [AW-1:0] S2_BASE = 32'h0002_0000,
  parameter logic [AW-1:0] S2_MASK = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_arvalid,
  output logic             m_arready,
  input  logic [AW-1:0]    m_araddr,
  input  logic [IDW-1:0]   m_arid,
  input  logic [3:0]       m_arlen,
  output logic             m_rvalid,
  input  logic             m_rready,
  output logic [DW-1:0]    m_rdata,
  output logic [IDW-1:0]   m_rid,
  output logic [1:0]       m_rresp,
  output logic             m_rlast,
  output logic [2:0]       s_arvalid,
  input  logic [2:0]       s_arready,
  output logic [AW-1:0]    s_araddr,
  output logic [IDW-1:0]   s_arid,
  output logic [3:0]       s_arlen,
  input  logic [2:0]       s_rvalid,
  output logic [2:0]       s_rready,
  input  logic [3*DW-1:0]  s_rdata,
  input  logic [3*IDW-1:0] s_rid,
  input  logic [5:0]       s_rresp,
  input  logic [2:0]       s_rlast,
  output logic             done
`ifdef AXI_RD_DECERR_CNT_EN
  , output logic [15:0]    decerr_cnt
`endif
);
  state_t         r_state, w_nxt;
  sel_t           r_sel, w_sel;
  logic [AW-1:0]  r_araddr;
  logic [IDW-1:0] r_arid;
  logic [3:0]     r_arlen;
  logic [2:0]     w_oh;
  logic           w_load_def;
  logic           w_s_rvalid, w_s_rlast;
  logic [DW-1:0]  w_s_rdata;
  logic [IDW-1:0] w_s_rid;
  logic [1:0]     w_s_rresp;
  logic           w_def_arready, w_def_rvalid, w_def_rlast;
  logic [DW-1:0]  w_def_rdata;
  logic [IDW-1:0] w_def_rid;
  logic [1:0]     w_def_rresp;
  // Lower slave index wins when address windows overlap.
  assign w_sel = ((m_araddr & S0_MASK) == S0_BASE) ? SEL_S0 :
                 ((m_araddr & S1_MASK) == S1_BASE) ? SEL_S1 :
                 ((m_araddr & S2_MASK) == S2_BASE) ? SEL_S2 : SEL_DEF;
  assign w_oh = (r_sel == SEL_S0) ? 3'b001 : (r_sel == SEL_S1) ? 3'b010 :
                (r_sel == SEL_S2) ? 3'b100 : 3'b000;
  assign w_load_def = (r_state == ST_IDLE) && m_arvalid && (w_sel == SEL_DEF);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= SEL_DEF;
      r_araddr <= '0;
      r_arid   <= '0;
      r_arlen  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_IDLE && m_arvalid) begin
        r_sel    <= w_sel;
        r_araddr <= m_araddr;
        r_arid   <= m_arid;
        r_arlen  <= m_arlen;
      end
    end
  end
  assign s_araddr = r_araddr;
  assign s_arid   = r_arid;
  assign s_arlen  = r_arlen;
  assign w_s_rvalid = |(s_rvalid & w_oh);
  assign w_s_rlast  = |(s_rlast & w_oh);
  assign w_s_rdata  = (r_sel == SEL_S1) ? s_rdata[DW +: DW] : (r_sel == SEL_S2) ? s_rdata[2*DW +: DW] : s_rdata[0 +: DW];
  assign w_s_rid    = (r_sel == SEL_S1) ? s_rid[IDW +: IDW] : (r_sel == SEL_S2) ? s_rid[2*IDW +: IDW] : s_rid[0 +: IDW];
  assign w_s_rresp  = (r_sel == SEL_S1) ? s_rresp[3:2] : (r_sel == SEL_S2) ? s_rresp[5:4] : s_rresp[1:0];
  axi_default_slave #(.DW(DW), .IDW(IDW)) u_def (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load_def),
    .i_en      (r_state == ST_DEF_DATA),
    .i_arlen   (r_arlen),
    .i_arid    (r_arid),
    .i_rready  (m_rready),
    .o_arready (w_def_arready),
    .o_rvalid  (w_def_rvalid),
    .o_rdata   (w_def_rdata),
    .o_rid     (w_def_rid),
    .o_rresp   (w_def_rresp),
    .o_rlast   (w_def_rlast)
  );
  always_comb begin
    w_nxt     = r_state;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rid     = '0;
    m_rresp   = RESP_OKAY;
    m_rlast   = 1'b0;
    s_arvalid = '0;
    s_rready  = '0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: if (m_arvalid) w_nxt = (w_sel == SEL_DEF) ? ST_DEF_DATA : ST_ADDR;
      ST_ADDR: begin
        s_arvalid = w_oh;
        m_arready = |(s_arready & w_oh);
        if (m_arready) w_nxt = ST_DATA;
      end
      ST_DATA: begin
        m_rvalid = w_s_rvalid;
        m_rdata  = w_s_rdata;
        m_rid    = w_s_rid;
        m_rresp  = w_s_rresp;
        m_rlast  = w_s_rlast;
        s_rready = m_rready ? w_oh : 3'b000;
        done     = m_rvalid & m_rready & m_rlast;
        if (done) w_nxt = ST_IDLE;
      end
      ST_DEF_DATA: begin
        m_arready = w_def_arready;
        m_rvalid  = w_def_rvalid;
        m_rdata   = w_def_rdata;
        m_rid     = w_def_rid;
        m_rresp   = w_def_rresp;
        m_rlast   = w_def_rlast;
        done      = m_rvalid & m_rready & m_rlast;
        if (done) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end
`ifdef AXI_RD_DECERR_CNT_EN
  logic [15:0] r_decerr_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_decerr_cnt <= '0;
    else if (w_load_def && r_decerr_cnt != 16'hFFFF) r_decerr_cnt <= r_decerr_cnt + 16'd1;
  end
  assign decerr_cnt = r_decerr_cnt;
`endif
endmodule

// File: tb/tb_axi_rd_decoder_3s.sv
// tb_axi_rd_decoder_3s: directed checks of decode, R routing, default-slave bursts and mid-burst reset.
module tb_axi_rd_decoder_3s;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_arvalid = 0, m_arready;
  logic [31:0] m_araddr = 0;
  logic [7:0]  m_arid = 0;
  logic [3:0]  m_arlen = 0;
  logic        m_rvalid, m_rready = 0, m_rlast;
  logic [31:0] m_rdata;
  logic [7:0]  m_rid;
  logic [1:0]  m_rresp;
  logic [2:0]  s_arvalid, s_arready = 0, s_rvalid = 0, s_rready, s_rlast = 0;
  logic [31:0] s_araddr;
  logic [7:0]  s_arid;
  logic [3:0]  s_arlen;
  logic [95:0] s_rdata = 0;
  logic [23:0] s_rid = 0;
  logic [5:0]  s_rresp = 0;
  logic        done;
`ifdef AXI_RD_DECERR_CNT_EN
  logic [15:0] decerr_cnt;
`endif
  int n_checks = 0, n_errs = 0;
  always #5 clk = ~clk;
  axi_rd_decoder_3s dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .done(done)
`ifdef AXI_RD_DECERR_CNT_EN
    , .decerr_cnt(decerr_cnt)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_arready"}, m_arready, 0);
    check({tag, "_rvalid"}, m_rvalid, 0);
    check({tag, "_rlast"}, m_rlast, 0);
    check({tag, "_s_arvalid"}, s_arvalid, 0);
    check({tag, "_s_rready"}, s_rready, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdata"}, m_rdata, 0);
    check({tag, "_rid"}, m_rid, 0);
    check({tag, "_rresp"}, m_rresp, 0);
  endtask
  task automatic ar_slave(input logic [31:0] a, input logic [7:0] id, input logic [3:0] len, input logic [2:0] oh);
    m_arvalid = 1; m_araddr = a; m_arid = id; m_arlen = len;
    #1 check("arready_idle", m_arready, 0);
    check("s_arvalid_idle", s_arvalid, 0);
    @(negedge clk); #1;
    check("s_arvalid", s_arvalid, oh);
    check("s_araddr", s_araddr, a);
    check("s_arid", s_arid, id);
    check("s_arlen", s_arlen, len);
    check("arready_wait", m_arready, 0);
    @(negedge clk);
    check("s_arvalid_hold", s_arvalid, oh);
    s_arready = oh;
    #1 check("m_arready", m_arready, 1);
    @(negedge clk);
    m_arvalid = 0; s_arready = 0;
    #1 check("s_arvalid_off", s_arvalid, 0);
  endtask
  task automatic slave_burst(input int s, input logic [3:0] len, input logic [7:0] id, input logic [31:0] base,
                             input bit toggle, input bit stray);
    int beats = 0, cyc = 0;
    bit rr = 1;
    logic [2:0] oh;
    logic [31:0] ed;
    oh = 3'b001 << s;
    while (beats <= int'(len) && cyc < 40) begin
      ed = base + 32'(beats);
      s_rvalid = oh | (stray ? 3'b001 : 3'b000);
      s_rdata = '0;
      s_rdata[s*32 +: 32] = ed;
      if (stray) s_rdata[31:0] = 32'h1111_1111;
      s_rid = '0;
      s_rid[s*8 +: 8] = id;
      s_rlast = '0;
      s_rlast[s] = (beats == int'(len));
      m_rready = rr;
      #1;
      check("s_rready", s_rready, rr ? oh : 3'b000);
      check("m_rvalid", m_rvalid, 1);
      check("m_rdata", m_rdata, ed);
      check("m_rid", m_rid, id);
      check("m_rresp", m_rresp, 2'b00);
      check("m_rlast", m_rlast, beats == int'(len));
      check("done", done, rr && beats == int'(len));
      if (stray) check("stray_leak", m_rdata == 32'h1111_1111, 0);
      if (rr) beats++;
      @(negedge clk);
      cyc++;
      rr = toggle ? ~rr : 1'b1;
    end
    s_rvalid = 0; s_rlast = 0; m_rready = 0;
    check("beat_count", beats, int'(len) + 1);
    #1 check("done_after", done, 0);
    check("s_rready_after", s_rready, 0);
  endtask
  task automatic def_burst(input logic [31:0] a, input logic [7:0] id, input logic [3:0] len);
    int beats = 0, cyc = 0;
    m_arvalid = 1; m_araddr = a; m_arid = id; m_arlen = len;
    @(negedge clk); #1;
    check("def_no_s_arvalid", s_arvalid, 0);
    check("def_arready", m_arready, 1);
    check("def_rvalid_entry", m_rvalid, 0);
    m_arvalid = 0; m_rready = 1;
    while (beats <= int'(len) && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      check("def_arready_low", m_arready, 0);
      if (m_rvalid) begin
        check("def_rdata", m_rdata, 0);
        check("def_rresp", m_rresp, 2'b11);
        check("def_rid", m_rid, id);
        check("def_rlast", m_rlast, beats == int'(len));
        check("def_done", done, beats == int'(len));
        beats++;
      end
    end
    check("def_beat_count", beats, int'(len) + 1);
    @(negedge clk); #1;
    m_rready = 0;
    check("def_done_after", done, 0);
    check("def_rvalid_after", m_rvalid, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    rst = 0;
    @(negedge clk);
    ar_slave(32'h0000_0100, 8'h5A, 4'd0, 3'b001);
    slave_burst(0, 4'd0, 8'h5A, 32'hDEAD_BEEF, 0, 0);
    ar_slave(32'h0002_0040, 8'h22, 4'd3, 3'b100);
    slave_burst(2, 4'd3, 8'h22, 32'h2000_0000, 1, 0);
    def_burst(32'h8000_0000, 8'h77, 4'd1);
`ifdef AXI_RD_DECERR_CNT_EN
    check("decerr_cnt_1", decerr_cnt, 16'd1);
`endif
    ar_slave(32'h0001_0200, 8'h31, 4'd2, 3'b010);
    slave_burst(1, 4'd2, 8'h31, 32'h3000_0000, 0, 1);
    ar_slave(32'h0001_0400, 8'h45, 4'd7, 3'b010);
    s_rvalid = 3'b010; s_rdata = '0; s_rdata[63:32] = 32'h4000_0000; s_rid = '0; s_rid[15:8] = 8'h45; m_rready = 1;
    @(negedge clk);
    s_rdata[63:32] = 32'h4000_0001;
    #1 check("mid_rvalid", m_rvalid, 1);
    check("mid_rdata", m_rdata, 32'h4000_0001);
    rst = 1;
    @(negedge clk); #1;
    check_idle_outputs("midrst");
    rst = 0; s_rvalid = 0; s_rdata = 0; s_rid = 0; m_rready = 0;
    @(negedge clk);
    ar_slave(32'h0000_0200, 8'h11, 4'd0, 3'b001);
    slave_burst(0, 4'd0, 8'h11, 32'h5000_0000, 0, 0);
    def_burst(32'h0000_4000, 8'h44, 4'd15);
`ifdef AXI_RD_DECERR_CNT_EN
    check("decerr_cnt_after_rst", decerr_cnt, 16'd1);
    force dut.r_decerr_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_decerr_cnt;
    for (int i = 0; i < 3; i++) def_burst(32'hF000_0000, 8'h99, 4'd0);
    check("decerr_cnt_sat", decerr_cnt, 16'hFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
